// File: rtl/uart_pkg.sv
// Shared types for the debug UART receive path: parity modes, receiver states
// and the tagged FIFO entry.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_HIGH
  } rx_state_e;

  typedef struct packed {
    logic       line_end;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] data;
  } uart_rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The reserved encoding behaves like "no parity".
  function automatic logic parity_enabled(input parity_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of tagged UART characters. A push while full is accepted
// only when a pop frees a slot in the same cycle; otherwise it is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  uart_rx_entry_t i_data,
  input  logic           i_pop,
  output uart_rx_entry_t o_data,
  output logic           o_full,
  output logic           o_empty,
  output logic [AW:0]    o_count
);

  uart_rx_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_line.sv
// Oversampling UART receiver for the debug console path; tagged characters are
// queued in a FIFO drained through a valid/ready port.
//
// state        | meaning
// IDLE         | line idle, watching for a 1->0 edge
// START        | checking the start bit (vote of 1 = false start)
// DATA         | shifting in data bits, LSB first
// PARITY       | checking the parity bit
// STOP1/STOP2  | checking stop bits; final vote pushes the character
// WAIT_HIGH    | line still low after a frame (break); wait for idle
module uart_rx_line
  import uart_pkg::*;
#(
  parameter  int         DATA_BITS  = 8,
  parameter  int         OVERSAMPLE = OVERSAMPLE_DEF,
  parameter  int         FIFO_DEPTH = 16,
  parameter  logic [7:0] LINE_CHAR  = 8'h0A,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   baud_div_i,
  input  logic [1:0]    parity_mode_i,
  input  logic          two_stop_i,
  input  logic          rx_i,
  output logic [7:0]    data_o,
  output logic          line_end_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overflow_o,
  input  logic          clear_i,
  output logic [CW-1:0] count_o
);

  localparam int            PW       = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_V0    = PW'(OVERSAMPLE/2 - 1);
  localparam logic [PW-1:0] PH_V1    = PW'(OVERSAMPLE/2);
  localparam logic [PW-1:0] PH_V2    = PW'(OVERSAMPLE/2 + 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic           r_rx_meta;
  logic           r_rx_sync;
  logic           r_rx_prev;
  logic [15:0]    r_tick_cnt;
  logic           w_tick;
  rx_state_e      r_state;
  rx_state_e      w_state_next;
  logic [PW-1:0]  r_phase;
  logic [1:0]     r_samp;
  logic           w_vote_tick;
  logic           w_vote;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_next;
  logic           r_par_err;
  logic           w_par_err;
  logic           r_frame_err;
  parity_mode_e   r_par_mode;
  logic           r_two_stop;
  logic           w_start;
  logic           w_shift_en;
  logic           w_par_en;
  logic           w_stop_en;
  logic           w_push_req;
  logic           r_push;
  uart_rx_entry_t r_entry;
  uart_rx_entry_t w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_ovf_set;
  logic [CW-1:0]  w_count;
  logic           r_overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Free-running; a new divider value is picked up at the next reload.
  assign w_tick = (r_tick_cnt == 16'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_tick_cnt <= 16'd0;
    else if (w_tick) r_tick_cnt <= baud_div_i;
    else             r_tick_cnt <= r_tick_cnt - 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase <= '0;
      r_samp  <= 2'b11;
    end else if (w_start) begin
      r_phase <= '0;
    end else if (w_tick) begin
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      if (r_phase == PH_V0) r_samp[0] <= r_rx_sync;
      if (r_phase == PH_V1) r_samp[1] <= r_rx_sync;
    end
  end

  // Every state advances on the third vote tick, so bit boundaries are implicit.
  assign w_vote_tick = w_tick && (r_phase == PH_V2);
  assign w_vote      = maj3(r_samp[0], r_samp[1], r_rx_sync);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (r_rx_prev && !r_rx_sync) w_state_next = ST_START;
      ST_START:
        if (w_vote_tick) w_state_next = w_vote ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (w_vote_tick && (r_bit_cnt == BIT_LAST))
          w_state_next = parity_enabled(r_par_mode) ? ST_PARITY : ST_STOP1;
      ST_PARITY:
        if (w_vote_tick) w_state_next = ST_STOP1;
      ST_STOP1:
        if (w_vote_tick) begin
          if (r_two_stop) w_state_next = ST_STOP2;
          else            w_state_next = w_vote ? ST_IDLE : ST_WAIT_HIGH;
        end
      ST_STOP2:
        if (w_vote_tick) w_state_next = w_vote ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH:
        if (r_rx_sync) w_state_next = ST_IDLE;
      default:
        w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_stop_en  = 1'b0;
    w_push_req = 1'b0;
    case (r_state)
      ST_IDLE:   w_start    = r_rx_prev && !r_rx_sync;
      ST_DATA:   w_shift_en = w_vote_tick;
      ST_PARITY: w_par_en   = w_vote_tick;
      ST_STOP1: begin
        w_stop_en  = w_vote_tick;
        w_push_req = w_vote_tick && !r_two_stop;
      end
      ST_STOP2: begin
        w_stop_en  = w_vote_tick;
        w_push_req = w_vote_tick;
      end
      default: ;
    endcase
  end

  // New bit enters at DATA_BITS-1 so the final value is already right-aligned.
  always_comb begin
    w_shift_next                = {1'b0, r_shift[7:1]};
    w_shift_next[DATA_BITS-1]   = w_vote;
  end

  assign w_par_err = ((^r_shift) ^ w_vote) != (r_par_mode == PAR_ODD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_mode  <= PAR_NONE;
      r_two_stop  <= 1'b0;
    end else if (w_start) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_mode  <= parity_mode_e'(parity_mode_i);
      r_two_stop  <= two_stop_i;
    end else begin
      if (w_shift_en) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_en)              r_par_err   <= w_par_err;
      if (w_stop_en && !w_vote)  r_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_push  <= 1'b0;
      r_entry <= '0;
    end else begin
      r_push <= w_push_req;
      if (w_push_req) begin
        r_entry.line_end   <= (r_shift == LINE_CHAR);
        r_entry.parity_err <= r_par_err;
        r_entry.frame_err  <= r_frame_err | ~w_vote;
        r_entry.data       <= r_shift;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (r_push),
    .i_data  (r_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign valid_o   = !w_empty;
  assign w_pop     = valid_o && ready_i;
  assign w_ovf_set = r_push && w_full && !w_pop;

  // A new drop wins over a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (clear_i)   r_overflow <= 1'b0;
  end

  assign data_o       = valid_o ? w_head.data : 8'h00;
  assign line_end_o   = valid_o && w_head.line_end;
  assign parity_err_o = valid_o && w_head.parity_err;
  assign frame_err_o  = valid_o && w_head.frame_err;
  assign overflow_o   = r_overflow;
  assign count_o      = w_count;

endmodule

// File: tb/tb_uart_rx_line.sv
// Scoreboard bench for uart_rx_line: directed frames at baud_div_i=0, 8 data
// bits, 16x oversampling, 4-entry FIFO.
module tb_uart_rx_line;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] baud_div_i;
  logic [1:0]  parity_mode_i;
  logic        two_stop_i;
  logic        rx_i;
  logic [7:0]  data_o;
  logic        line_end_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;
  logic        clear_i;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  uart_rx_line #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4),
    .LINE_CHAR  (8'h0A)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .baud_div_i    (baud_div_i),
    .parity_mode_i (parity_mode_i),
    .two_stop_i    (two_stop_i),
    .rx_i          (rx_i),
    .data_o        (data_o),
    .line_end_o    (line_end_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .overflow_o    (overflow_o),
    .clear_i       (clear_i),
    .count_o       (count_o)
  );

  // Monitor: every pop is compared against the oldest expected entry.
  always @(negedge clk_i) begin
    logic [10:0] e;
    if (!rst_i && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry: got {le,pe,fe,data}=%b_%b_%b_%h, none expected",
                 line_end_o, parity_err_o, frame_err_o, data_o);
      end else begin
        e = exp_q.pop_front();
        if ({line_end_o, parity_err_o, frame_err_o, data_o} !== e) begin
          failures++;
          $display("FAIL entry: got {le,pe,fe,data}=%b_%b_%b_%h expected %b_%b_%b_%h",
                   line_end_o, parity_err_o, frame_err_o, data_o,
                   e[10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [7:0] d, input logic pe, input logic fe);
    exp_q.push_back({(d == 8'h0A), pe, fe, d});
  endtask

  task automatic bit_out(input logic v);
    rx_i = v;
    repeat (16) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop1, input logic two, input logic stop2);
    @(negedge clk_i);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (par_on) bit_out(par_bit);
    bit_out(stop1);
    if (two) bit_out(stop2);
    rx_i = 1'b1;
    repeat (16) @(negedge clk_i);
  endtask

  task automatic send8n1(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL %s_drain_timeout: got %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0; clear_i = 1'b0;
    baud_div_i = 16'd0; parity_mode_i = 2'b00; two_stop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_count", 32'(count_o), 0);
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_overflow", 32'(overflow_o), 0);
    chk("reset_data", 32'(data_o), 0);
    chk("reset_flags", 32'({line_end_o, parity_err_o, frame_err_o}), 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // 8N1 line with a newline
    expect_entry(8'h41, 1'b0, 1'b0); send8n1(8'h41);
    expect_entry(8'h0A, 1'b0, 1'b0); send8n1(8'h0A);
    chk("8n1_count", 32'(count_o), 2);
    chk("8n1_valid", 32'(valid_o), 1);
    ready_i = 1'b1;
    drain("8n1");

    // parity: 0x03 has even popcount, parity bit 1
    parity_mode_i = 2'b01;
    expect_entry(8'h03, 1'b1, 1'b0); send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    parity_mode_i = 2'b10;
    expect_entry(8'h03, 1'b0, 1'b0); send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("parity");
    parity_mode_i = 2'b00;

    // glitch shorter than half a bit
    @(negedge clk_i); rx_i = 1'b0;
    repeat (4) @(negedge clk_i); rx_i = 1'b1;
    repeat (40) @(negedge clk_i);
    chk("glitch_count", 32'(count_o), 0);
    chk("glitch_valid", 32'(valid_o), 0);
    expect_entry(8'h55, 1'b0, 1'b0); send8n1(8'h55);
    drain("after_glitch");

    // break: one entry only
    expect_entry(8'h00, 1'b0, 1'b1);
    @(negedge clk_i); rx_i = 1'b0;
    repeat (20*16) @(negedge clk_i); rx_i = 1'b1;
    repeat (32) @(negedge clk_i);
    drain("break");
    repeat (20) @(negedge clk_i);
    chk("break_single", 32'(count_o), 0);

    // 8N2 with second stop bit low
    two_stop_i = 1'b1;
    expect_entry(8'h5A, 1'b0, 1'b1); send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("8n2");
    two_stop_i = 1'b0;

    // overflow: fifth character dropped
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_entry(8'h31 + 8'(i), 1'b0, 1'b0);
      send8n1(8'h31 + 8'(i));
    end
    chk("ovf_count", 32'(count_o), 4);
    chk("ovf_flag", 32'(overflow_o), 1);
    @(negedge clk_i); clear_i = 1'b1;
    @(negedge clk_i); clear_i = 1'b0;
    chk("ovf_cleared", 32'(overflow_o), 0);
    ready_i = 1'b1;
    drain("ovf");

    // full FIFO, pop in the push cycle
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_entry(8'h61 + 8'(i), 1'b0, 1'b0);
      send8n1(8'h61 + 8'(i));
    end
    expect_entry(8'h65, 1'b0, 1'b0);
    fork
      send8n1(8'h65);
      begin
        @(negedge clk_i);
        repeat (157) @(posedge clk_i);
        #1 ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
      end
    join
    chk("simul_overflow", 32'(overflow_o), 0);
    chk("simul_count", 32'(count_o), 4);
    ready_i = 1'b1;
    drain("simul");

    // reset during data bit 3 with an entry pending
    ready_i = 1'b0;
    send8n1(8'h11);
    chk("prereset_count", 32'(count_o), 1);
    fork
      send8n1(8'hA5);
      begin
        @(negedge clk_i);
        repeat (2 + 16*4 + 8) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_data", 32'(data_o), 0);
        chk("midrst_flags", 32'({line_end_o, parity_err_o, frame_err_o, overflow_o}), 0);
      end
    join
    @(negedge clk_i); rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("postrst_count", 32'(count_o), 0);
    ready_i = 1'b1;
    expect_entry(8'hA5, 1'b0, 1'b0); send8n1(8'hA5);
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
